// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation search controller.
// Holds the default parameter values and the FSM state encoding used by
// me_search_ctrl and its bus interface.
package me_pkg;

  localparam int SW_LENGTH_DEF = 18;
  localparam int TB_LENGTH_DEF = 16;
  localparam int SAD_W_DEF     = 16;
  localparam int VEC_W_DEF     = 4;
  localparam int DLY_SAD_DEF   = 2;
  localparam int PIPE_LAT_DEF  = 3;
  localparam int NPASS_MAX_DEF = 4;
  localparam int MVEC_W        = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_DRAIN  = 3'd2,
    S_UPDATE = 3'd3,
    S_ACK    = 3'd4
  } me_state_e;

endpackage

// File: rtl/me_search_ctrl_if.sv
// Request/result bus between a search requester and me_search_ctrl.
//   master (requester): drives req, npass, thresh, init_pos;
//                       receives ack, busy, init_mvec, min_sad, min_diff, pass_idx.
//   slave  (controller): the reverse directions.
interface me_search_ctrl_if
  import me_pkg::*;
#(
  parameter int NPASS_MAX = NPASS_MAX_DEF,
  parameter int SAD_W     = SAD_W_DEF,
  parameter int VEC_W     = VEC_W_DEF
) ();

  localparam int NPASS_W = $clog2(NPASS_MAX + 1);
  localparam int PIDX_W  = (NPASS_MAX > 1) ? $clog2(NPASS_MAX) : 1;

  logic                 req;
  logic [NPASS_W-1:0]   npass;
  logic [SAD_W-1:0]     thresh;
  logic [MVEC_W-1:0]    init_pos;
  logic                 ack;
  logic                 busy;
  logic [MVEC_W-1:0]    init_mvec;
  logic [SAD_W-1:0]     min_sad;
  logic [VEC_W-1:0]     min_diff;
  logic [PIDX_W-1:0]    pass_idx;

  modport master (
    output req, npass, thresh, init_pos,
    input  ack, busy, init_mvec, min_sad, min_diff, pass_idx
  );

  modport slave (
    input  req, npass, thresh, init_pos,
    output ack, busy, init_mvec, min_sad, min_diff, pass_idx
  );

endinterface

// File: rtl/me_dly_line.sv
// Fixed-depth shift register, cleared by reset.
//   clk, rst : clock and asynchronous active-high reset
//   din      : WIDTH-bit input
//   dout     : din delayed by DEPTH cycles (DEPTH >= 1)
module me_dly_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/me_search_ctrl.sv
// Motion-estimation search controller. Sequences the search-window and
// template-block address generators over one or more full-window scans,
// waits for the SAD array to drain, and keeps the best (lowest) SAD.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : request/result handshake, see me_search_ctrl_if
//   sad, vec_diff   : SAD-array result, sampled in UPDATE
//   clr             : SAD-array clear
//   en_addr_sw/tb   : address-generator enables
//   en_sadarray_*   : address enables delayed by DLY_SAD cycles
//
// state  | meaning
// IDLE   | waiting for req; SAD array held clear
// SCAN   | walking the SW_LENGTH x SW_LENGTH window, one address per cycle
// DRAIN  | letting the delayed enables and SAD pipeline empty
// UPDATE | compare sad against best so far; decide next pass or finish
// ACK    | result valid; waits for req to drop
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int SW_LENGTH = SW_LENGTH_DEF,
  parameter int TB_LENGTH = TB_LENGTH_DEF,
  parameter int SAD_W     = SAD_W_DEF,
  parameter int VEC_W     = VEC_W_DEF,
  parameter int DLY_SAD   = DLY_SAD_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int NPASS_MAX = NPASS_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  me_search_ctrl_if.slave  bus,
  input  logic [SAD_W-1:0] sad,
  input  logic [VEC_W-1:0] vec_diff,
  output logic             clr,
  output logic             en_addr_sw,
  output logic             en_addr_tb,
  output logic             en_sadarray_sw,
  output logic             en_sadarray_tb
);

  localparam int CNT_W   = $clog2(SW_LENGTH);
  localparam int NPASS_W = $clog2(NPASS_MAX + 1);
  localparam int PIDX_W  = (NPASS_MAX > 1) ? $clog2(NPASS_MAX) : 1;
  localparam int DRN_N   = DLY_SAD + PIPE_LAT;
  localparam int DRN_W   = $clog2(DRN_N + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SW_LENGTH - 1);
  localparam logic [CNT_W-1:0]   WIN_START = CNT_W'(SW_LENGTH - TB_LENGTH);
  localparam logic [DRN_W-1:0]   DRN_LOAD  = DRN_W'(DRN_N - 1);
  localparam logic [NPASS_W-1:0] NPASS_CAP = NPASS_W'(NPASS_MAX);

  me_state_e           state;
  logic [CNT_W-1:0]    cnt_h, cnt_w;
  logic [DRN_W-1:0]    dcnt;
  logic [NPASS_W-1:0]  npass_q;
  logic [SAD_W-1:0]    thresh_q;
  logic [MVEC_W-1:0]   init_mvec_q;
  logic [SAD_W-1:0]    min_sad_q;
  logic [VEC_W-1:0]    min_diff_q;
  logic [PIDX_W-1:0]   pass_idx_q;
  logic                busy_q, ack_q;
  logic                en_sw_q, en_tb_q;

  logic                sad_better, finish, scan_last, tb_window;
  logic [SAD_W-1:0]    min_sad_upd;
  logic [NPASS_W-1:0]  pass_cnt, npass_eff;
  logic [1:0]          sa_en;

  // 0 means one pass; requests above NPASS_MAX are clamped so pass_idx cannot wrap.
  assign npass_eff = (bus.npass == '0)       ? NPASS_W'(1) :
                     (bus.npass > NPASS_CAP) ? NPASS_CAP   : bus.npass;

  assign sad_better  = sad < min_sad_q;
  assign min_sad_upd = sad_better ? sad : min_sad_q;
  assign pass_cnt    = NPASS_W'(pass_idx_q) + NPASS_W'(1);
  assign finish      = (pass_cnt >= npass_q) || (min_sad_upd <= thresh_q);
  assign scan_last   = (cnt_h == CNT_LAST) && (cnt_w == CNT_LAST);
  assign tb_window   = (state == S_SCAN) && (cnt_h >= WIN_START) && (cnt_w >= WIN_START);

  // clr depends on the sad presented during UPDATE, so it cannot be
  // registered without stretching UPDATE; it is a decode of state instead.
  assign clr = (state == S_IDLE) || ((state == S_UPDATE) && !finish);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt_h       <= '0;
      cnt_w       <= '0;
      dcnt        <= '0;
      npass_q     <= '0;
      thresh_q    <= '0;
      init_mvec_q <= '0;
      min_sad_q   <= '1;
      min_diff_q  <= '0;
      pass_idx_q  <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      en_sw_q     <= 1'b0;
      en_tb_q     <= 1'b0;
    end else begin
      en_tb_q <= tb_window;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            state       <= S_SCAN;
            npass_q     <= npass_eff;
            thresh_q    <= bus.thresh;
            init_mvec_q <= bus.init_pos;
            min_sad_q   <= '1;
            min_diff_q  <= '0;
            pass_idx_q  <= '0;
            busy_q      <= 1'b1;
            en_sw_q     <= 1'b1;
          end
        end
        S_SCAN: begin
          if (scan_last) begin
            state   <= S_DRAIN;
            cnt_h   <= '0;
            cnt_w   <= '0;
            dcnt    <= DRN_LOAD;
            en_sw_q <= 1'b0;
          end else if (cnt_h == CNT_LAST) begin
            cnt_h <= '0;
            cnt_w <= cnt_w + CNT_W'(1);
          end else begin
            cnt_h <= cnt_h + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt == '0) state <= S_UPDATE;
          else            dcnt  <= dcnt - DRN_W'(1);
        end
        S_UPDATE: begin
          if (sad_better) begin
            min_sad_q  <= sad;
            min_diff_q <= vec_diff;
          end
          if (finish) begin
            state  <= S_ACK;
            busy_q <= 1'b0;
            ack_q  <= 1'b1;
          end else begin
            state      <= S_SCAN;
            pass_idx_q <= pass_idx_q + PIDX_W'(1);
            en_sw_q    <= 1'b1;
          end
        end
        S_ACK: begin
          if (!bus.req) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  me_dly_line #(
    .WIDTH (2),
    .DEPTH (DLY_SAD)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({en_sw_q, en_tb_q}),
    .dout (sa_en)
  );

  assign en_addr_sw     = en_sw_q;
  assign en_addr_tb     = en_tb_q;
  assign en_sadarray_sw = sa_en[1];
  assign en_sadarray_tb = sa_en[0];

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.init_mvec = init_mvec_q;
  assign bus.min_sad   = min_sad_q;
  assign bus.min_diff  = min_diff_q;
  assign bus.pass_idx  = pass_idx_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// Testbench for me_search_ctrl: table of directed and random searches checked
// against a pass-by-pass reference model, plus reset and req-hold sequences.
module tb_me_search_ctrl;
  import me_pkg::*;

  localparam int SW   = 18;
  localparam int TB   = 16;
  localparam int SADW = 16;
  localparam int VECW = 4;
  localparam int DLY  = 2;
  localparam int PIPE = 3;
  localparam int NPM  = 4;
  localparam int NPW  = $clog2(NPM + 1);
  localparam int PASS_CYC = SW * SW + DLY + PIPE + 1;

  typedef struct packed {
    int                npass;
    int                thresh;
    int                init_pos;
    logic [3:0][15:0]  sad;
    logic [3:0][3:0]   vec;
    bit                hold;
    int                exp_sad;
    int                exp_diff;
    int                exp_pidx;
    int                exp_passes;
  } vec_t;

  logic            clk, rst;
  logic [SADW-1:0] sad;
  logic [VECW-1:0] vec_diff;
  logic            clr, en_addr_sw, en_addr_tb, en_sadarray_sw, en_sadarray_tb;

  me_search_ctrl_if #(.NPASS_MAX(NPM), .SAD_W(SADW), .VEC_W(VECW)) bus ();

  me_search_ctrl #(
    .SW_LENGTH(SW), .TB_LENGTH(TB), .SAD_W(SADW), .VEC_W(VECW),
    .DLY_SAD(DLY), .PIPE_LAT(PIPE), .NPASS_MAX(NPM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .sad            (sad),
    .vec_diff       (vec_diff),
    .clr            (clr),
    .en_addr_sw     (en_addr_sw),
    .en_addr_tb     (en_addr_tb),
    .en_sadarray_sw (en_sadarray_sw),
    .en_sadarray_tb (en_sadarray_tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int np, input int th, input int ip,
                              input int s0, input int s1, input int s2, input int s3,
                              input int v0, input int v1, input int v2, input int v3,
                              input bit hold, input int es, input int ed,
                              input int ep, input int en);
    vec_t v;
    v = '0;
    v.npass = np; v.thresh = th; v.init_pos = ip;
    v.sad[0] = 16'(s0); v.sad[1] = 16'(s1); v.sad[2] = 16'(s2); v.sad[3] = 16'(s3);
    v.vec[0] = 4'(v0);  v.vec[1] = 4'(v1);  v.vec[2] = 4'(v2);  v.vec[3] = 4'(v3);
    v.hold = hold; v.exp_sad = es; v.exp_diff = ed; v.exp_pidx = ep; v.exp_passes = en;
    return v;
  endfunction

  // Reference: run passes in order, keep the strictly smaller SAD, stop on
  // the last requested pass or once the best SAD is at or below threshold.
  function automatic vec_t model(input vec_t v);
    int ne, best, diff;
    ne   = (v.npass == 0) ? 1 : ((v.npass > NPM) ? NPM : v.npass);
    best = 65535;
    diff = 0;
    for (int p = 0; p < ne; p++) begin
      if (int'(v.sad[p]) < best) begin
        best = int'(v.sad[p]);
        diff = int'(v.vec[p]);
      end
      if (p + 1 >= ne || best <= v.thresh) begin
        v.exp_passes = p + 1;
        v.exp_pidx   = p;
        break;
      end
    end
    v.exp_sad  = best;
    v.exp_diff = diff;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},     64'(bus.busy),       64'd0);
    chk({tag, "_ack"},      64'(bus.ack),        64'd0);
    chk({tag, "_en_sw"},    64'(en_addr_sw),     64'd0);
    chk({tag, "_en_tb"},    64'(en_addr_tb),     64'd0);
    chk({tag, "_sa_sw"},    64'(en_sadarray_sw), 64'd0);
    chk({tag, "_sa_tb"},    64'(en_sadarray_tb), 64'd0);
    chk({tag, "_pass_idx"}, 64'(bus.pass_idx),   64'd0);
    chk({tag, "_min_sad"},  64'(bus.min_sad),    64'd65535);
    chk({tag, "_min_diff"}, 64'(bus.min_diff),   64'd0);
    chk({tag, "_init_mv"},  64'(bus.init_mvec),  64'd0);
    chk({tag, "_clr"},      64'(clr),            64'd1);
  endtask

  task automatic run_search(input vec_t v, input string tag);
    int  cyc, pc, sidx, n_sw, n_tb, n_ssw, n_stb, n_clr, pat_err, dly_err, stab;
    bit  prev_sw, got_ack, seen_busy, exp_tb;
    logic [1:0] hist[$];
    int  budget;
    budget = NPM * PASS_CYC + 40;
    pc = 0; sidx = 100000; n_sw = 0; n_tb = 0; n_ssw = 0; n_stb = 0; n_clr = 0;
    pat_err = 0; dly_err = 0; prev_sw = 1'b0; got_ack = 1'b0; seen_busy = 1'b0;
    @(negedge clk);
    bus.npass    = NPW'(v.npass);
    bus.thresh   = 16'(v.thresh);
    bus.init_pos = 12'(v.init_pos);
    sad          = v.sad[0];
    vec_diff     = v.vec[0];
    bus.req      = 1'b1;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (!seen_busy && bus.busy) begin
        seen_busy = 1'b1;
        chk({tag, "_min_init"}, 64'(bus.min_sad), 64'd65535);
        chk({tag, "_init_mvec"}, 64'(bus.init_mvec), 64'(v.init_pos & 12'hFFF));
        if (!v.hold) bus.req = 1'b0;
      end
      if (en_addr_sw && !prev_sw) begin
        sidx = 0;
        if (pc < 4) begin
          sad      = v.sad[pc];
          vec_diff = v.vec[pc];
        end
        pc++;
      end else begin
        sidx++;
      end
      prev_sw = en_addr_sw;
      exp_tb = (sidx >= 1) && (sidx <= SW * SW) &&
               (((sidx - 1) % SW) >= SW - TB) && (((sidx - 1) / SW) >= SW - TB);
      if (en_addr_tb !== exp_tb) pat_err++;
      if (en_addr_sw)     n_sw++;
      if (en_addr_tb)     n_tb++;
      if (en_sadarray_sw) n_ssw++;
      if (en_sadarray_tb) n_stb++;
      if (clr && bus.busy) n_clr++;
      hist.push_back({en_addr_sw, en_addr_tb});
      if (hist.size() > DLY) begin
        if ({en_sadarray_sw, en_sadarray_tb} !== hist[0]) dly_err++;
        void'(hist.pop_front());
      end
      if (bus.ack) begin
        got_ack = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 64'(got_ack), 64'd1);
    chk({tag, "_latency"},  64'(cyc - 1), 64'(v.exp_passes * PASS_CYC));
    chk({tag, "_n_en_sw"},  64'(n_sw),    64'(v.exp_passes * SW * SW));
    chk({tag, "_n_en_tb"},  64'(n_tb),    64'(v.exp_passes * TB * TB));
    chk({tag, "_n_sa_sw"},  64'(n_ssw),   64'(v.exp_passes * SW * SW));
    chk({tag, "_n_sa_tb"},  64'(n_stb),   64'(v.exp_passes * TB * TB));
    chk({tag, "_n_clr"},    64'(n_clr),   64'(v.exp_passes - 1));
    chk({tag, "_tb_pat"},   64'(pat_err), 64'd0);
    chk({tag, "_dly"},      64'(dly_err), 64'd0);
    chk({tag, "_min_sad"},  64'(bus.min_sad),  64'(v.exp_sad));
    chk({tag, "_min_diff"}, 64'(bus.min_diff), 64'(v.exp_diff));
    chk({tag, "_pass_idx"}, 64'(bus.pass_idx), 64'(v.exp_pidx));
    chk({tag, "_busy_off"}, 64'(bus.busy),     64'd0);
    if (v.hold) begin
      stab = 0;
      repeat (50) begin
        @(negedge clk);
        if (bus.busy || !bus.ack || en_addr_sw ||
            bus.min_sad !== 16'(v.exp_sad) || bus.min_diff !== 4'(v.exp_diff)) stab++;
      end
      chk({tag, "_hold_no_restart"}, 64'(stab), 64'd0);
      bus.req = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_ack_drop"}, 64'(bus.ack),     64'd0);
    chk({tag, "_min_kept"}, 64'(bus.min_sad), 64'(v.exp_sad));
  endtask

  initial begin
    bit   seen;
    int   stray;
    vec_t v;
    rst = 1'b1; bus.req = 1'b0; bus.npass = '0; bus.thresh = '0; bus.init_pos = '0;
    sad = '0; vec_diff = '0;

    tbl.push_back(mk(1, 0,   12'h123, 1234, 0,   0,   0,   5, 0, 0, 0, 0, 1234, 5, 0, 1));
    tbl.push_back(mk(3, 0,   12'h456, 500,  200, 300, 0,   1, 2, 3, 0, 0, 200,  2, 2, 3));
    tbl.push_back(mk(4, 250, 12'h0AB, 400,  240, 9,   9,   4, 6, 1, 1, 0, 240,  6, 1, 2));
    tbl.push_back(mk(2, 0,   12'h777, 100,  100, 0,   0,   3, 7, 0, 0, 0, 100,  3, 1, 2));
    tbl.push_back(mk(0, 0,   12'h001, 77,   5,   0,   0,   9, 1, 0, 0, 0, 77,   9, 0, 1));
    tbl.push_back(mk(3, 300, 12'hFFF, 300,  10,  10,  0,   2, 1, 1, 0, 0, 300,  2, 0, 1));
    tbl.push_back(mk(1, 0,   12'h0F0, 65535, 0,  0,   0,   8, 0, 0, 0, 0, 65535, 0, 0, 1));
    tbl.push_back(mk(4, 5,   12'h5A5, 900,  800, 800, 100, 1, 2, 3, 4, 0, 100,  4, 3, 4));
    tbl.push_back(mk(2, 0,   12'h321, 50,   60,  0,   0,  11, 12, 0, 0, 1, 50,  11, 1, 2));
    tbl.push_back(mk(1, 0,   12'h9C3, 600,  0,   0,   0,   2, 0, 0, 0, 0, 600,  2, 0, 1));

    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_search(tbl[i], $sformatf("dir%0d", i));

    // Reset in the middle of a scan, then a clean search afterwards.
    @(negedge clk);
    bus.npass = NPW'(3); bus.thresh = '0; bus.init_pos = 12'hABC; bus.req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (en_addr_sw) begin
        seen = 1'b1;
        break;
      end
    end
    chk("midrst_scan_start", 64'(seen), 64'd1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.ack || bus.busy) stray++;
    end
    chk("midrst_no_ack", 64'(stray), 64'd0);
    run_search(tbl[1], "post_rst");

    for (int r = 0; r < 6; r++) begin
      v = '0;
      v.npass    = int'($urandom_range(0, 4));
      v.thresh   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 700)) : 0;
      v.init_pos = int'($urandom_range(0, 4095));
      for (int p = 0; p < 4; p++) begin
        v.sad[p] = 16'($urandom_range(0, 800));
        if (p > 0 && $urandom_range(0, 3) == 0) v.sad[p] = v.sad[p-1];
        v.vec[p] = 4'($urandom_range(0, 15));
      end
      v.hold = 1'($urandom_range(0, 1));
      v = model(v);
      run_search(v, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
